axi_read_arbiter: RTL
=====================

# axi_read_arbiter

Shares one full-AXI read port, such as the input of the AXI-to-AXI-lite read bridge, between NM independent AXI read masters. It grants one master at a time and forwards that master's AR request downstream. It routes the returning R beats back to the granted master and holds the grant until the RLAST beat completes. Only one burst is outstanding downstream at any time.

## Interface
Parameters:
- NM, 2: number of upstream masters, 2..8.
- IW, 2: AXI ID width.
- AW, 6: address width.
- DW, 32: data width.

Ports:
- S_AXI_ACLK  in  1  clock.
- S_AXI_ARESETN  in  1  reset, asynchronous, active-low.
- S_AXI_ARVALID  in  NM  per-master AR valid.
- S_AXI_ARREADY  out  NM  per-master AR ready.
- S_AXI_ARID  in  NM*IW  flattened; master i occupies bits [i*IW +: IW]. Same packing for all flattened AR buses.
- S_AXI_ARADDR  in  NM*AW  flattened.
- S_AXI_ARLEN  in  NM*8  flattened.
- S_AXI_ARSIZE  in  NM*3  flattened.
- S_AXI_ARBURST  in  NM*2  flattened.
- S_AXI_RVALID  out  NM  per-master R valid.
- S_AXI_RREADY  in  NM  per-master R ready.
- S_AXI_RID  out  IW  broadcast to all masters.
- S_AXI_RDATA  out  DW  broadcast.
- S_AXI_RRESP  out  2  broadcast.
- S_AXI_RLAST  out  1  broadcast.
- M_AXI_ARVALID  out  1  downstream AR valid.
- M_AXI_ARREADY  in  1  downstream AR ready.
- M_AXI_ARID  out  IW  downstream AR ID.
- M_AXI_ARADDR  out  AW  downstream AR address.
- M_AXI_ARLEN  out  8  downstream AR length.
- M_AXI_ARSIZE  out  3  downstream AR size.
- M_AXI_ARBURST  out  2  downstream AR burst type.
- M_AXI_RVALID  in  1  downstream R valid.
- M_AXI_RREADY  out  1  downstream R ready.
- M_AXI_RID  in  IW  downstream R ID.
- M_AXI_RDATA  in  DW  downstream R data.
- M_AXI_RRESP  in  2  downstream R response.
- M_AXI_RLAST  in  1  downstream R last.
- o_grant  out  $clog2(NM)  index of the current or last granted master.
- o_busy  out  1  state is not IDLE.
- o_err_rlast  out  1  one-cycle pulse on an RLAST/beat-count mismatch.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE: if any S_AXI_ARVALID is high, register the winner in grant and go to ADDR. Otherwise stay in IDLE.
- Round-robin: search starts at last_grant+1 modulo NM and takes the first asserted valid. On reset, last_grant = NM-1, so master 0 wins the first contention.
- ADDR:
  - M_AXI_AR* is a combinational mux of the granted master's fields.
  - M_AXI_ARVALID = 1.
  - S_AXI_ARREADY[grant] = M_AXI_ARREADY; all other ARREADY bits are 0.
  - On handshake: capture ARLEN into len_q, clear beat counter, go to DATA.
- DATA:
  - M_AXI_RREADY = S_AXI_RREADY[grant].
  - S_AXI_RVALID[grant] = M_AXI_RVALID; all other RVALID bits are 0.
  - S_AXI_R* data fields pass through combinationally.
  - Each R handshake increments the 8-bit beat counter.
  - The RLAST handshake sets last_grant = grant and goes to IDLE.
- o_err_rlast pulses on an R handshake where (beat == len_q) != M_AXI_RLAST. The FSM still ends the burst only on RLAST.
- M_AXI_RREADY and every S_AXI_RVALID bit are 0 outside DATA. Every S_AXI_ARREADY bit is 0 outside ADDR.
- Masters must hold ARVALID and payload stable until ARREADY (AXI rule). The arbiter does not re-arbitrate while in ADDR.

## Timing
- Reset values: state IDLE, grant 0, last_grant NM-1, beat 0, len_q 0.
- Reset output values:
  - M_AXI_ARVALID = 0, M_AXI_RREADY = 0.
  - S_AXI_ARREADY = 0, S_AXI_RVALID = 0.
  - o_busy = 0, o_err_rlast = 0, o_grant = 0.
  - AR mux output = master 0 fields.
- Latency: S_AXI_ARVALID rising in IDLE gives M_AXI_ARVALID high on the next cycle. R path has 0 cycles of latency (combinational).
- Back-to-back bursts have one IDLE bubble cycle after the RLAST handshake.
- Simultaneous requests: exactly one grant per IDLE cycle. A master requesting every cycle waits at most NM-1 bursts.
- Single-beat burst (ARLEN=0): the first beat must carry RLAST. If it does not, o_err_rlast pulses and the FSM stays in DATA until RLAST arrives.
- Beat counter wraps at 255 (modulo 256). This is only reachable after an error.
- Reset mid-burst: asynchronous return to IDLE and all valids drop immediately. The downstream slave must be reset on the same net; any in-flight beats are discarded.

## Configuration
- AXI_RD_ARB_FIXED_PRIO_EN defined: fixed priority, lowest asserted index always wins. last_grant is not used for selection; it is still updated.
- AXI_RD_ARB_FIXED_PRIO_EN undefined (default): round-robin as described above.

## Test plan
- Single request: master 1 sends ARADDR=0x10, ARLEN=3 with ARREADY held high.
  - M_AXI_ARVALID is high 1 cycle after ARVALID.
  - 4 R beats reach only S_AXI_RVALID[1].
  - RLAST on beat 4; o_busy falls the cycle after.
- Contention: masters 0 and 1 both request continuously with ARLEN=0.
  - Grant order is 0,1,0,1.
  - With AXI_RD_ARB_FIXED_PRIO_EN the order is 0,0,0,0.
- Backpressure: M_AXI_ARREADY is held low 5 cycles, then S_AXI_RREADY toggles every cycle during the burst.
  - AR payload stays stable throughout.
  - No beat is lost or duplicated; M_AXI_RREADY mirrors S_AXI_RREADY[grant].
- RLAST mismatch: ARLEN=2 with RLAST on beat 2.
  - o_err_rlast pulses once.
  - FSM returns to IDLE after that RLAST handshake.
- Reset during DATA after beat 1 of ARLEN=7:
  - All outputs return to reset values within the same cycle as the reset assertion.
  - After reset release, master 0 wins the first contention.

Source files
------------

// File: rtl/axi_read_arbiter_if.sv
// Bus bundle for axi_read_arbiter: NM flattened upstream AXI read ports plus one downstream read port.
// Modport slave is the arbiter's view; modport master is the view of the masters and downstream slave.
interface axi_read_arbiter_if #(
  parameter int NM = 2,
  parameter int IW = 2,
  parameter int AW = 6,
  parameter int DW = 32
);
  logic [NM-1:0]    S_AXI_ARVALID;
  logic [NM-1:0]    S_AXI_ARREADY;
  logic [NM*IW-1:0] S_AXI_ARID;
  logic [NM*AW-1:0] S_AXI_ARADDR;
  logic [NM*8-1:0]  S_AXI_ARLEN;
  logic [NM*3-1:0]  S_AXI_ARSIZE;
  logic [NM*2-1:0]  S_AXI_ARBURST;
  logic [NM-1:0]    S_AXI_RVALID;
  logic [NM-1:0]    S_AXI_RREADY;
  logic [IW-1:0]    S_AXI_RID;
  logic [DW-1:0]    S_AXI_RDATA;
  logic [1:0]       S_AXI_RRESP;
  logic             S_AXI_RLAST;

  logic             M_AXI_ARVALID;
  logic             M_AXI_ARREADY;
  logic [IW-1:0]    M_AXI_ARID;
  logic [AW-1:0]    M_AXI_ARADDR;
  logic [7:0]       M_AXI_ARLEN;
  logic [2:0]       M_AXI_ARSIZE;
  logic [1:0]       M_AXI_ARBURST;
  logic             M_AXI_RVALID;
  logic             M_AXI_RREADY;
  logic [IW-1:0]    M_AXI_RID;
  logic [DW-1:0]    M_AXI_RDATA;
  logic [1:0]       M_AXI_RRESP;
  logic             M_AXI_RLAST;

  modport slave (
    input  S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
    input  S_AXI_RREADY,
    output S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
    output M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    output M_AXI_RREADY,
    input  M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST
  );

  modport master (
    output S_AXI_ARVALID, S_AXI_ARID, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARSIZE, S_AXI_ARBURST,
    output S_AXI_RREADY,
    input  S_AXI_ARREADY, S_AXI_RVALID, S_AXI_RID, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST,
    input  M_AXI_ARVALID, M_AXI_ARID, M_AXI_ARADDR, M_AXI_ARLEN, M_AXI_ARSIZE, M_AXI_ARBURST,
    input  M_AXI_RREADY,
    output M_AXI_ARREADY, M_AXI_RVALID, M_AXI_RID, M_AXI_RDATA, M_AXI_RRESP, M_AXI_RLAST
  );
endinterface

// File: rtl/axi_read_arbiter.sv
// Shares one AXI read port among NM masters, one burst outstanding, grant held until RLAST.
// Define AXI_RD_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); default is round-robin.
module axi_read_arbiter #(
  parameter int NM = 2,
  parameter int IW = 2,
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESETN,
  axi_read_arbiter_if.slave      bus,
  output logic [$clog2(NM)-1:0]  o_grant,
  output logic                   o_busy,
  output logic                   o_err_rlast,
  output logic [1:0]             o_state
);
  localparam int GW = $clog2(NM);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ADDR = 2'd1, ST_DATA = 2'd2} state_t;

  state_t        state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [7:0]    beat_q, beat_d;
  logic [7:0]    len_q, len_d;

  logic [GW-1:0] winner;
  logic [NM-1:0] grant_oh;
  logic [IW-1:0] sel_arid;
  logic [AW-1:0] sel_araddr;
  logic [7:0]    sel_arlen;
  logic [2:0]    sel_arsize;
  logic [1:0]    sel_arburst;
  logic          sel_rready;
  logic          ar_hs;
  logic          r_hs;

  always_comb begin
    winner = last_grant_q;
`ifdef AXI_RD_ARB_FIXED_PRIO_EN
    for (int i = NM - 1; i >= 0; i--) begin
      if (bus.S_AXI_ARVALID[i]) winner = GW'(i);
    end
`else
    // Walk the search order backwards so the first requester after last_grant is assigned last.
    for (int k = NM; k >= 1; k--) begin
      for (int i = 0; i < NM; i++) begin
        if (i == (int'(last_grant_q) + k) % NM && bus.S_AXI_ARVALID[i]) winner = GW'(i);
      end
    end
`endif
  end

  always_comb begin
    grant_oh    = '0;
    sel_arid    = '0;
    sel_araddr  = '0;
    sel_arlen   = '0;
    sel_arsize  = '0;
    sel_arburst = '0;
    sel_rready  = 1'b0;
    for (int i = 0; i < NM; i++) begin
      if (grant_q == GW'(i)) begin
        grant_oh[i] = 1'b1;
        sel_arid    = bus.S_AXI_ARID[i*IW +: IW];
        sel_araddr  = bus.S_AXI_ARADDR[i*AW +: AW];
        sel_arlen   = bus.S_AXI_ARLEN[i*8 +: 8];
        sel_arsize  = bus.S_AXI_ARSIZE[i*3 +: 3];
        sel_arburst = bus.S_AXI_ARBURST[i*2 +: 2];
        sel_rready  = bus.S_AXI_RREADY[i];
      end
    end
  end

  assign ar_hs = (state_q == ST_ADDR) && bus.M_AXI_ARREADY;
  assign r_hs  = (state_q == ST_DATA) && bus.M_AXI_RVALID && sel_rready;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= ST_IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(NM - 1);
      beat_q       <= '0;
      len_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      beat_q       <= beat_d;
      len_q        <= len_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    beat_d       = beat_q;
    len_d        = len_q;
    case (state_q)
      ST_IDLE: begin
        if (|bus.S_AXI_ARVALID) begin
          grant_d = winner;
          state_d = ST_ADDR;
        end
      end
      ST_ADDR: begin
        if (ar_hs) begin
          len_d   = sel_arlen;
          beat_d  = '0;
          state_d = ST_DATA;
        end
      end
      ST_DATA: begin
        // A miscounted burst still only ends on RLAST; the counter wraps if it overruns.
        if (r_hs) begin
          beat_d = beat_q + 8'd1;
          if (bus.M_AXI_RLAST) begin
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.M_AXI_ARVALID = (state_q == ST_ADDR);
    bus.S_AXI_ARREADY = ar_hs ? grant_oh : '0;
    bus.M_AXI_RREADY  = (state_q == ST_DATA) && sel_rready;
    bus.S_AXI_RVALID  = ((state_q == ST_DATA) && bus.M_AXI_RVALID) ? grant_oh : '0;
    o_err_rlast       = r_hs && ((beat_q == len_q) != bus.M_AXI_RLAST);
    o_busy            = (state_q != ST_IDLE);
    o_grant           = grant_q;
    o_state           = state_q;
  end

  assign bus.M_AXI_ARID    = sel_arid;
  assign bus.M_AXI_ARADDR  = sel_araddr;
  assign bus.M_AXI_ARLEN   = sel_arlen;
  assign bus.M_AXI_ARSIZE  = sel_arsize;
  assign bus.M_AXI_ARBURST = sel_arburst;
  assign bus.S_AXI_RID     = bus.M_AXI_RID;
  assign bus.S_AXI_RDATA   = bus.M_AXI_RDATA;
  assign bus.S_AXI_RRESP   = bus.M_AXI_RRESP;
  assign bus.S_AXI_RLAST   = bus.M_AXI_RLAST;
endmodule
